// File: rtl/dispense_seq2.sv
// Pour-order sequencer for the emit3 stage: arms the stage, acknowledges each
// completed unit with a four-phase handshake and reports when the order is done.
module dispense_seq2 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             abort,
    input  logic             count2,
    output logic             load3,
    output logic             out_ctrl,
    output logic             count_ACK2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] served
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_ACK  = 3'd3,
        ST_REL  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   target_r;
    logic [CNT_W-1:0]   target_s;
    logic [CNT_W-1:0]   served_r;
    logic [CNT_W-1:0]   served_s;
    logic               abort_r;
    logic               abort_s;
    logic               load3_r;
    logic               load3_s;
    logic               out_ctrl_r;
    logic               out_ctrl_s;
    logic               ack_r;
    logic               ack_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s  = state_r;
        target_s = target_r;
        served_s = served_r;
        abort_s  = abort_r;
        case (state_r)
            ST_IDLE: begin
                abort_s = 1'b0;
                if (start) begin
                    target_s = target;
                    served_s = {CNT_W{1'b0}};
                    if (target == {CNT_W{1'b0}}) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (count2) begin
                    state_s  = ST_ACK;
                    served_s = served_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ACK: begin
                // Abort here only kills the enable; the handshake still finishes.
                if (abort) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = abort_r;
                end
                state_s = ST_REL;
            end
            ST_REL: begin
                if (abort) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = abort_r;
                end
                if (count2) begin
                    state_s = ST_REL;
                end else if (abort_r || abort) begin
                    state_s = ST_IDLE;
                end else if (served_r == target_r) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        load3_s    = (state_s == ST_LOAD);
        ack_s      = (state_s == ST_ACK) || (state_s == ST_REL);
        out_ctrl_s = ((state_s == ST_LOAD) || (state_s == ST_RUN) || ack_s) && !abort_s;
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_FIN);
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_r    <= ST_IDLE;
            target_r   <= {CNT_W{1'b0}};
            served_r   <= {CNT_W{1'b0}};
            abort_r    <= 1'b0;
            load3_r    <= 1'b0;
            out_ctrl_r <= 1'b0;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            target_r   <= target_s;
            served_r   <= served_s;
            abort_r    <= abort_s;
            load3_r    <= load3_s;
            out_ctrl_r <= out_ctrl_s;
            ack_r      <= ack_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign load3      = load3_r;
    assign out_ctrl   = out_ctrl_r;
    assign count_ACK2 = ack_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign served     = served_r;

endmodule

// File: tb/tb_dispense_seq2.sv
// Self-checking bench for dispense_seq2: a pour-level reference model compared
// every cycle, plus literal checks of unit, pulse and served totals per scenario.
module tb_dispense_seq2;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             RESET;
    logic             start;
    logic [CNT_W-1:0] target;
    logic             abort;
    logic             count2;
    logic             load3;
    logic             out_ctrl;
    logic             count_ACK2;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] served;

    int tests = 0;
    int fails = 0;

    dispense_seq2 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .RESET(RESET), .start(start), .target(target),
        .abort(abort), .count2(count2), .load3(load3), .out_ctrl(out_ctrl),
        .count_ACK2(count_ACK2), .busy(busy), .done(done), .served(served)
    );

    always #5 clk = ~clk;

    // Reference model: a pour is a sequence of units; each unit is a load
    // cycle, a wait for the emit stage, then an open handshake.
    bit m_load = 1'b0;
    bit m_run  = 1'b0;
    bit m_hs   = 1'b0;
    bit m_hs_new = 1'b0;
    bit m_abt  = 1'b0;
    bit m_fin  = 1'b0;
    int m_served = 0;
    int m_tgt  = 0;

    initial forever begin
        @(posedge clk or negedge RESET);
        if (!RESET) begin
            m_load = 1'b0; m_run = 1'b0; m_hs = 1'b0; m_hs_new = 1'b0;
            m_abt = 1'b0; m_fin = 1'b0; m_served = 0; m_tgt = 0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_hs) begin
            if (abort) m_abt = 1'b1;
            if (m_hs_new) begin
                m_hs_new = 1'b0;
            end else if (!count2) begin
                m_hs = 1'b0;
                if (m_abt) m_abt = 1'b0;
                else if (m_served == m_tgt) m_fin = 1'b1;
                else m_load = 1'b1;
            end
        end else if (m_load) begin
            m_load = 1'b0;
            m_run  = !abort;
        end else if (m_run) begin
            if (abort) begin
                m_run = 1'b0;
            end else if (count2) begin
                m_run = 1'b0; m_hs = 1'b1; m_hs_new = 1'b1;
                m_served = m_served + 1;
            end
        end else if (start) begin
            m_tgt = int'(target);
            m_served = 0;
            if (target == 8'd0) m_fin = 1'b1;
            else m_load = 1'b1;
        end
    end

    // Per-cycle comparison and pulse counters.
    int n_load = 0;
    int n_done = 0;
    int n_ack  = 0;
    bit ack_prev = 1'b0;
    logic [CNT_W+4:0] got;
    logic [CNT_W+4:0] exp_v;

    initial forever begin
        @(negedge clk);
        got   = {load3, out_ctrl, count_ACK2, busy, done, served};
        exp_v = {m_load, (m_load | m_run | m_hs) & !m_abt, m_hs,
                 m_load | m_run | m_hs | m_fin, m_fin, CNT_W'(m_served)};
        tests++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL cycle_model t=%0t got={ld,oc,ack,busy,done,srv}=%b want=%b", $time, got, exp_v);
        end
        n_load += int'(load3);
        n_done += int'(done);
        if (count_ACK2 && !ack_prev) n_ack++;
        ack_prev = count_ACK2;
    end

    task automatic check(input string name, input int act, input int exp_i);
        tests++;
        if (act != exp_i) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp_i);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s got=timeout want=event", name);
    endtask

    task automatic start_pour(input int t);
        @(negedge clk);
        start  = 1'b1;
        target = CNT_W'(t);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_load(output bit ok);
        int n = 0;
        while (!load3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = load3;
        if (!ok) timeout("wait_load3");
    endtask

    task automatic wait_ack(output bit ok);
        int n = 0;
        while (!count_ACK2 && n < 40) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        ok = count_ACK2;
        if (!ok) timeout("wait_ack");
    endtask

    // Emit-stage responder for one unit; poke issues a start while busy.
    task automatic emit_unit(input int d_load, input int d_ack, input bit poke, output bit ok);
        wait_load(ok);
        if (ok) begin
            repeat (d_load) @(negedge clk);
            if (poke) begin
                start  = 1'b1;
                target = 8'd7;
            end
            count2 = 1'b1;
            wait_ack(ok);
            repeat (d_ack) @(negedge clk);
            count2 = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    int s_load, s_done, s_ack;
    bit ok;

    initial begin
        RESET = 1'b0; start = 1'b1; count2 = 1'b1; target = 8'd5; abort = 1'b0;

        // 1: reset with start and count2 asserted
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({load3, out_ctrl, count_ACK2, busy, done, served}), 0);
        RESET = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_ack", int'(count_ACK2), 0);
        check("idle_not_busy", int'(busy), 0);
        count2 = 1'b0;
        @(negedge clk);

        // 2: three-unit pour
        s_load = n_load; s_done = n_done; s_ack = n_ack;
        start_pour(3);
        for (int i = 0; i < 3; i++) begin
            emit_unit(5, 2, 1'b0, ok);
            if (!ok) break;
        end
        repeat (5) @(negedge clk);
        check("t3_loads", n_load - s_load, 3);
        check("t3_acks", n_ack - s_ack, 3);
        check("t3_done", n_done - s_done, 1);
        check("t3_served", int'(served), 3);

        // 3: zero target
        s_load = n_load; s_done = n_done;
        start_pour(0);
        check("t0_done_pulse", int'(done), 1);
        repeat (4) @(negedge clk);
        check("t0_loads", n_load - s_load, 0);
        check("t0_done", n_done - s_done, 1);
        check("t0_served", int'(served), 0);

        // 4: abort in RUN after two units
        s_load = n_load; s_done = n_done;
        start_pour(4);
        for (int i = 0; i < 2; i++) begin
            emit_unit(3, 1, 1'b0, ok);
            if (!ok) break;
        end
        wait_load(ok);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abrun_out_ctrl", int'(out_ctrl), 0);
        check("abrun_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        check("abrun_served", int'(served), 2);
        check("abrun_done", n_done - s_done, 0);
        check("abrun_loads", n_load - s_load, 3);

        // 5: abort during handshake, count2 held 4 more cycles
        s_load = n_load; s_done = n_done;
        start_pour(5);
        emit_unit(2, 1, 1'b0, ok);
        wait_load(ok);
        repeat (2) @(negedge clk);
        count2 = 1'b1;
        wait_ack(ok);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abhs_ack_held", int'(count_ACK2), 1);
        check("abhs_out_ctrl", int'(out_ctrl), 0);
        count2 = 1'b0;
        repeat (6) @(negedge clk);
        check("abhs_served", int'(served), 2);
        check("abhs_busy", int'(busy), 0);
        check("abhs_done", n_done - s_done, 0);
        check("abhs_loads", n_load - s_load, 2);

        // 6: full-range pour with a start issued mid-pour
        s_load = n_load; s_done = n_done; s_ack = n_ack;
        start_pour(255);
        for (int i = 0; i < 255; i++) begin
            emit_unit(1, 1, i == 10, ok);
            if (!ok) break;
        end
        repeat (5) @(negedge clk);
        check("full_served", int'(served), 255);
        check("full_loads", n_load - s_load, 255);
        check("full_acks", n_ack - s_ack, 255);
        check("full_done", n_done - s_done, 1);
        check("full_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
